// File: rtl/rca_multicycle_add_ctrl_pkg.sv
// Shared definitions for the word-serial wide adder controller:
// FSM state encoding and slice-count / counter-width derivations.
package rca_multicycle_add_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of slice cycles needed to cover the full operand width.
  function automatic int num_slices(input int total_width, input int slice_width);
    return total_width / slice_width;
  endfunction

  // Ceiling log2, never less than one bit so a single-slice counter still exists.
  function automatic int clog2_min1(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    if (result < 1) begin
      result = 1;
    end else begin
      result = result;
    end
    return result;
  endfunction

endpackage

// File: rtl/rca_multicycle_add_ctrl_rca_adder.sv
// Parameterised ripple-carry adder; purely combinational, carry ripples from bit 0 upward.
module RCA_adder #(
  parameter int BIT_WIDTH = 16
) (
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 c_in,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 c_out
);

  logic [BIT_WIDTH:0] carry_s;

  // Full-adder chain, one bit per iteration.
  always_comb begin
    sum        = '0;
    carry_s    = '0;
    carry_s[0] = c_in;
    for (int i = 0; i < BIT_WIDTH; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry_s[i];
      carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end
  end

  assign c_out = carry_s[BIT_WIDTH];

endmodule

// File: rtl/rca_multicycle_add_ctrl.sv
// Word-serial wide adder: one SLICE_WIDTH ripple-carry slice is sequenced over
// NUM_SLICES cycles, LSB slice first, with a registered inter-slice carry.
module rca_multicycle_add_ctrl
  import rca_multicycle_add_ctrl_pkg::*;
#(
  parameter int TOTAL_WIDTH = 64,
  parameter int SLICE_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TOTAL_WIDTH-1:0] a,
  input  logic [TOTAL_WIDTH-1:0] b,
  input  logic                   c_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TOTAL_WIDTH-1:0] sum,
  output logic                   c_out,
  output logic                   busy
);

  localparam int NUM_SLICES = num_slices(TOTAL_WIDTH, SLICE_WIDTH);
  localparam int CNT_W      = clog2_min1(NUM_SLICES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICES - 1);

  state_e                 state_r;
  state_e                 state_nx_s;
  logic [CNT_W-1:0]       cnt_r;
  logic                   carry_r;
  logic [TOTAL_WIDTH-1:0] a_sh_r;
  logic [TOTAL_WIDTH-1:0] b_sh_r;
  logic [TOTAL_WIDTH-1:0] acc_r;
  logic [TOTAL_WIDTH-1:0] acc_nx_s;
  logic [SLICE_WIDTH-1:0] slice_sum_s;
  logic                   slice_carry_s;
  logic                   load_s;
  logic                   step_s;
  logic                   last_s;

  RCA_adder #(
    .BIT_WIDTH(SLICE_WIDTH)
  ) u_slice (
    .a    (a_sh_r[SLICE_WIDTH-1:0]),
    .b    (b_sh_r[SLICE_WIDTH-1:0]),
    .c_in (carry_r),
    .sum  (slice_sum_s),
    .c_out(slice_carry_s)
  );

  // Reset must block acceptance in the same cycle, so in_ready looks at rst directly.
  assign in_ready = (state_r == ST_IDLE) & ~rst;

  // New slice result enters at the top; after NUM_SLICES shifts the LSB slice sits at bit 0.
  assign acc_nx_s = TOTAL_WIDTH'({slice_sum_s, acc_r} >> SLICE_WIDTH);

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    step_s     = 1'b0;
    last_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          load_s     = 1'b1;
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        step_s = 1'b1;
        if (cnt_r == LAST_CNT) begin
          last_s     = 1'b1;
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Operand shift registers, inter-slice carry, accumulator and slice counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      acc_r   <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
    end else if (load_s) begin
      a_sh_r  <= a;
      b_sh_r  <= b;
      carry_r <= c_in;
      cnt_r   <= '0;
    end else if (step_s) begin
      a_sh_r  <= a_sh_r >> SLICE_WIDTH;
      b_sh_r  <= b_sh_r >> SLICE_WIDTH;
      acc_r   <= acc_nx_s;
      carry_r <= slice_carry_s;
      cnt_r   <= cnt_r + CNT_W'(1);
    end
  end

  // Visible result and status; sum only ever takes a completed accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      c_out     <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (last_s) begin
        sum   <= acc_nx_s;
        c_out <= slice_carry_s;
      end
      out_valid <= (state_nx_s == ST_DONE);
      busy      <= (state_nx_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_rca_multicycle_add_ctrl.sv
// Directed and randomised self-checking bench for rca_multicycle_add_ctrl,
// covering slice widths 16 (4 slices), 64 (1 slice) and 8 (8 slices).
module tb_rca_multicycle_add_ctrl;

  logic        clk;
  logic        rst;
  logic [63:0] a;
  logic [63:0] b;
  logic        c_in;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [63:0] sum       [3];
  logic        c_out     [3];
  logic        busy      [3];

  int checks = 0;
  int errors = 0;

  rca_multicycle_add_ctrl #(.TOTAL_WIDTH(64), .SLICE_WIDTH(16)) dut_s16 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a), .b(b), .c_in(c_in), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .sum(sum[0]), .c_out(c_out[0]), .busy(busy[0])
  );

  rca_multicycle_add_ctrl #(.TOTAL_WIDTH(64), .SLICE_WIDTH(64)) dut_s64 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a), .b(b), .c_in(c_in), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .sum(sum[1]), .c_out(c_out[1]), .busy(busy[1])
  );

  rca_multicycle_add_ctrl #(.TOTAL_WIDTH(64), .SLICE_WIDTH(8)) dut_s8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a), .b(b), .c_in(c_in), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .sum(sum[2]), .c_out(c_out[2]), .busy(busy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction on DUT k: accept, latency, result, optional backpressure, release.
  task automatic run_op(input int k, input logic [63:0] av, input logic [63:0] bv,
                        input logic cv, input int exp_lat, input int hold, input string tag);
    int n;
    logic [64:0] exp_res;
    exp_res = {1'b0, av} + {1'b0, bv} + 65'(cv);
    a = av; b = bv; c_in = cv; in_valid[k] = 1'b1;
    n = 0;
    while (in_ready[k] !== 1'b1 && n < 20) begin tick(); n++; end
    check({tag, " accept"}, 65'(in_ready[k]), 65'd1);
    tick();
    in_valid[k] = 1'b0;
    n = 0;
    while (out_valid[k] !== 1'b1 && n < 40) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; c_in = 1'($urandom);
      tick();
      n++;
    end
    check({tag, " latency"}, 65'(n), 65'(exp_lat));
    check({tag, " result"}, {c_out[k], sum[k]}, exp_res);
    for (int h = 0; h < hold; h++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; in_valid[k] = 1'($urandom);
      tick();
      check({tag, " hold valid"}, 65'(out_valid[k]), 65'd1);
      check({tag, " hold ready"}, 65'(in_ready[k]), 65'd0);
      check({tag, " hold result"}, {c_out[k], sum[k]}, exp_res);
    end
    in_valid[k] = 1'b0;
    out_ready[k] = 1'b1;
    tick();
    out_ready[k] = 1'b0;
    check({tag, " release valid"}, 65'(out_valid[k]), 65'd0);
    check({tag, " release ready"}, 65'(in_ready[k]), 65'd1);
  endtask

  initial begin
    int lat [3];
    logic any_valid;
    lat[0] = 4; lat[1] = 1; lat[2] = 8;
    rst = 1'b1; a = 64'hDEAD_BEEF_CAFE_F00D; b = 64'h1234_5678_9ABC_DEF0; c_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b1; out_ready[k] = 1'b0;
    end

    // Reset held three cycles with in_valid asserted.
    tick(); tick(); tick();
    check("rst in_ready", 65'(in_ready[0]), 65'd0);
    check("rst out_valid", 65'(out_valid[0]), 65'd0);
    check("rst result", {c_out[0], sum[0]}, 65'd0);
    check("rst busy", 65'(busy[0]), 65'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) in_valid[k] = 1'b0;
    #1;
    check("post-rst in_ready", 65'(in_ready[0]), 65'd1);
    tick();
    check("post-rst busy", 65'(busy[0]), 65'd0);
    check("post-rst out_valid", 65'(out_valid[0]), 65'd0);

    // Carry ripples through every slice.
    run_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 4, 0, "ripple");
    check("ripple exact", {c_out[0], sum[0]}, 65'h1_0000_0000_0000_0000);
    // Top-bit carry out only.
    run_op(0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 4, 0, "msb carry");
    check("msb carry exact", {c_out[0], sum[0]}, 65'h1_0000_0000_0000_0000);
    // Slice-boundary carries, with ten cycles of backpressure in DONE.
    run_op(0, 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 4, 10, "boundary");
    check("boundary exact", {c_out[0], sum[0]}, 65'h0_0001_0000_0001_0000);

    // Reset while RUN has counter==2.
    a = 64'h1111_2222_3333_4444; b = 64'h5555_6666_7777_8888; c_in = 1'b0;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    tick(); tick();
    check("mid-run busy", 65'(busy[0]), 65'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid-run rst busy", 65'(busy[0]), 65'd0);
    check("mid-run rst result", {c_out[0], sum[0]}, 65'd0);
    any_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      any_valid = any_valid | out_valid[0];
      tick();
    end
    check("mid-run no out_valid", 65'(any_valid), 65'd0);
    run_op(0, 64'd5, 64'd7, 1'b0, 4, 0, "after rst");
    check("after rst exact", {c_out[0], sum[0]}, 65'd12);

    // Single-slice and eight-slice configurations: directed corner.
    run_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1, 1, "s64 ripple");
    run_op(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 8, 1, "s8 ripple");

    // Random operands with random gaps and backpressure on each configuration.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 300; i++) begin
        int gap;
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) tick();
        run_op(k, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
               lat[k], int'($urandom_range(0, 3)), "random");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
